// File: rtl/clock_div_sequencer.sv
// Lock-gated programmable clock divider: produces a divided clock, a period-start
// enable strobe and a phase index once PLL lock has been stable for LOCK_HOLD cycles.
module clock_div_sequencer #(
  parameter int unsigned DIV_WIDTH   = 4,
  parameter int unsigned DIV_DEFAULT = 5,
  parameter int unsigned LOCK_HOLD   = 255,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pll_lock,
  input  logic [DIV_WIDTH-1:0] div_sel,
  input  logic                 div_load,
  input  logic                 lock_lost_clr,
  output logic                 clk_div,
  output logic                 clk_en,
  output logic [DIV_WIDTH-1:0] phase,
  output logic                 ready,
  output logic                 lock_lost,
  output logic [CNT_WIDTH-1:0] lock_lost_count
);

  localparam logic [DIV_WIDTH-1:0] DIV_MIN     = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] DIV_RST     = DIV_WIDTH'(DIV_DEFAULT);
  localparam logic [CNT_WIDTH-1:0] SETTLE_LAST = CNT_WIDTH'(LOCK_HOLD - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;

  state_t               state, state_nxt;
  logic                 sync1, slock;
  logic [CNT_WIDTH-1:0] settle_cnt, settle_nxt;
  logic [DIV_WIDTH-1:0] div_cur, div_cur_nxt, div_pend, div_pend_nxt;
  logic                 pend, pend_nxt;
  logic [DIV_WIDTH-1:0] phase_nxt;
  logic                 clk_div_nxt, clk_en_nxt, ready_nxt, lost_set;
  logic                 lock_lost_nxt;
  logic [CNT_WIDTH-1:0] lost_cnt_nxt;
  logic [DIV_WIDTH-1:0] load_val, eff_pend;
  logic                 have_pend, wrap;

  // Two-flop synchroniser for the asynchronous lock input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      slock <= 1'b0;
    end else begin
      sync1 <= pll_lock;
      slock <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_LOCK;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_LOCK: if (slock) state_nxt = SETTLE;
      SETTLE: begin
        if (!slock)                       state_nxt = WAIT_LOCK;
        else if (settle_cnt == SETTLE_LAST) state_nxt = RUN;
      end
      RUN:       if (!slock) state_nxt = WAIT_LOCK;
      default:   state_nxt = WAIT_LOCK;
    endcase
  end

  // A load in the current cycle bypasses the pending register so it can land on this wrap
  assign load_val  = (div_sel < DIV_MIN) ? DIV_MIN : div_sel;
  assign eff_pend  = div_load ? load_val : div_pend;
  assign have_pend = div_load | pend;
  assign wrap      = (phase == div_cur - DIV_WIDTH'(1));

  always_comb begin
    phase_nxt    = '0;
    clk_div_nxt  = 1'b0;
    clk_en_nxt   = 1'b0;
    ready_nxt    = 1'b0;
    lost_set     = 1'b0;
    settle_nxt   = settle_cnt;
    div_cur_nxt  = div_cur;
    div_pend_nxt = eff_pend;
    pend_nxt     = have_pend;
    case (state)
      WAIT_LOCK: begin
        settle_nxt = '0;
        if (have_pend) begin
          div_cur_nxt = eff_pend;
          pend_nxt    = 1'b0;
        end
      end
      SETTLE: begin
        if (have_pend) begin
          div_cur_nxt = eff_pend;
          pend_nxt    = 1'b0;
        end
        if (!slock) begin
          lost_set = 1'b1;
        end else if (settle_cnt == SETTLE_LAST) begin
          ready_nxt   = 1'b1;
          clk_en_nxt  = 1'b1;
          clk_div_nxt = 1'b1;
        end else begin
          settle_nxt = settle_cnt + CNT_WIDTH'(1);
        end
      end
      RUN: begin
        if (!slock) begin
          lost_set = 1'b1;
        end else begin
          ready_nxt = 1'b1;
          if (wrap) begin
            phase_nxt = '0;
            if (have_pend) begin
              div_cur_nxt = eff_pend;
              pend_nxt    = 1'b0;
            end
          end else begin
            phase_nxt = phase + DIV_WIDTH'(1);
          end
          clk_en_nxt  = (phase_nxt == '0);
          clk_div_nxt = (phase_nxt < (div_cur_nxt >> 1));
        end
      end
      default: settle_nxt = '0;
    endcase
    lock_lost_nxt = lost_set | (lock_lost & ~lock_lost_clr);
    lost_cnt_nxt  = (lost_set && lock_lost_count != CNT_MAX) ?
                    lock_lost_count + CNT_WIDTH'(1) : lock_lost_count;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt      <= '0;
      div_cur         <= DIV_RST;
      div_pend        <= DIV_RST;
      pend            <= 1'b0;
      phase           <= '0;
      clk_div         <= 1'b0;
      clk_en          <= 1'b0;
      ready           <= 1'b0;
      lock_lost       <= 1'b0;
      lock_lost_count <= '0;
    end else begin
      settle_cnt      <= settle_nxt;
      div_cur         <= div_cur_nxt;
      div_pend        <= div_pend_nxt;
      pend            <= pend_nxt;
      phase           <= phase_nxt;
      clk_div         <= clk_div_nxt;
      clk_en          <= clk_en_nxt;
      ready           <= ready_nxt;
      lock_lost       <= lock_lost_nxt;
      lock_lost_count <= lost_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_clock_div_sequencer.sv
// Bench for clock_div_sequencer: per-edge vector table with a scoreboard queue, plus
// hand sequences for asynchronous reset and lock-loss counter saturation.
module tb_clock_div_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_lock, div_load, lock_lost_clr;
  logic [3:0] div_sel;
  logic       clk_div, clk_en, ready, lock_lost;
  logic [3:0] phase;
  logic [7:0] lock_lost_count;

  logic       pll_lock2;
  logic [3:0] div_sel2 = 4'd0;
  logic       div_load2 = 1'b0, clr2 = 1'b0;
  logic       clk_div2, clk_en2, ready2, lock_lost2;
  logic [3:0] phase2;
  logic [1:0] lost_cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clock_div_sequencer #(.DIV_WIDTH(4), .DIV_DEFAULT(5), .LOCK_HOLD(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .pll_lock(pll_lock), .div_sel(div_sel), .div_load(div_load),
    .lock_lost_clr(lock_lost_clr), .clk_div(clk_div), .clk_en(clk_en), .phase(phase),
    .ready(ready), .lock_lost(lock_lost), .lock_lost_count(lock_lost_count));

  clock_div_sequencer #(.DIV_WIDTH(4), .DIV_DEFAULT(5), .LOCK_HOLD(1), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .pll_lock(pll_lock2), .div_sel(div_sel2), .div_load(div_load2),
    .lock_lost_clr(clr2), .clk_div(clk_div2), .clk_en(clk_en2), .phase(phase2),
    .ready(ready2), .lock_lost(lock_lost2), .lock_lost_count(lost_cnt2));

  typedef struct {
    logic       lock, load, clr;
    logic [3:0] sel;
    logic       rdy, cd, ce;
    logic [3:0] ph;
    logic       ll;
    logic [7:0] cnt;
  } vec_t;

  typedef struct {
    logic       rdy, cd, ce;
    logic [3:0] ph;
    logic       ll;
    logic [7:0] cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic void add(logic lk, logic ld, int sel, logic cl,
                              logic r, logic cd, logic ce, int ph, logic ll, int cnt);
    vec_t v;
    v.lock = lk; v.load = ld; v.sel = 4'(sel); v.clr = cl;
    v.rdy = r; v.cd = cd; v.ce = ce; v.ph = 4'(ph); v.ll = ll; v.cnt = 8'(cnt);
    vecs.push_back(v);
  endfunction

  // Steady RUN rows with lock held: phase walks (start+k) mod n, high for the first n/2 phases
  function automatic void add_run(int rows, int n, int start, logic ll, int cnt);
    for (int k = 0; k < rows; k++) begin
      int ph;
      ph = (start + k) % n;
      add(1'b1, 1'b0, 0, 1'b0, 1'b1, ph < n / 2, ph == 0, ph, ll, cnt);
    end
  endfunction

  task automatic check1(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic wait_ready2(logic val, string name);
    int n = 0;
    while (ready2 !== val && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    check1(name, int'(ready2 === val), 1);
  endtask

  initial begin
    rst = 1'b1; pll_lock = 1'b0; div_load = 1'b0; div_sel = 4'd0; lock_lost_clr = 1'b0;
    pll_lock2 = 1'b0;

    // Lock acquisition, then N=5 steady state
    for (int i = 0; i < 6; i++) add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_run(7, 5, 0, 0, 0);
    // Load 8 at phase 1: current 5-cycle period completes, then 4/4 period
    add(1, 1, 8, 0, 1, 0, 0, 2, 0, 0);
    add_run(2, 5, 3, 0, 0);
    add_run(9, 8, 0, 0, 0);
    // Load 0 then 1 mid-period: last wins, clamps to 2 at the wrap
    add(1, 1, 0, 0, 1, 1, 0, 1, 0, 0);
    add(1, 1, 1, 0, 1, 1, 0, 2, 0, 0);
    add_run(5, 8, 3, 0, 0);
    add_run(5, 2, 0, 0, 0);
    // N=3, then a load of 0 in the wrap cycle lands on that wrap
    add(1, 1, 3, 0, 1, 0, 0, 1, 0, 0);
    add_run(3, 3, 0, 0, 0);
    add(1, 1, 0, 0, 1, 1, 1, 0, 0, 0);
    add_run(3, 2, 1, 0, 0);
    // Lock loss in RUN seen three edges later, then clear
    add(0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    // Re-lock needs the full settle sequence
    for (int i = 0; i < 6; i++) add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add_run(2, 2, 0, 0, 1);
    // Second loss with clear asserted on the setting edge: set wins
    add(0, 0, 0, 0, 1, 1, 1, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 1, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0, 1, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    // Loss after two settle increments returns to WAIT_LOCK and counts
    add(1, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    add(1, 0, 0, 1, 0, 0, 0, 0, 0, 2);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
    for (int i = 0; i < 6; i++) add(1, 0, 0, 0, 0, 0, 0, 0, 1, 3);
    add_run(2, 2, 0, 1, 3);

    repeat (3) @(posedge clk);
    #1;
    check1("reset_outputs", int'({ready, clk_div, clk_en, phase, lock_lost, lock_lost_count}), 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      exp_t e;
      exp_t got;
      pll_lock = vecs[i].lock; div_load = vecs[i].load;
      div_sel = vecs[i].sel;   lock_lost_clr = vecs[i].clr;
      e.rdy = vecs[i].rdy; e.cd = vecs[i].cd; e.ce = vecs[i].ce;
      e.ph = vecs[i].ph;   e.ll = vecs[i].ll; e.cnt = vecs[i].cnt;
      sb.push_back(e);
      @(posedge clk); #1;
      got.rdy = ready; got.cd = clk_div; got.ce = clk_en;
      got.ph = phase;  got.ll = lock_lost; got.cnt = lock_lost_count;
      e = sb.pop_front();
      checks++;
      if (got.rdy !== e.rdy || got.cd !== e.cd || got.ce !== e.ce ||
          got.ph !== e.ph || got.ll !== e.ll || got.cnt !== e.cnt) begin
        failures++;
        $display("FAIL row%0d: got rdy=%b div=%b en=%b ph=%0d ll=%b cnt=%0d expected rdy=%b div=%b en=%b ph=%0d ll=%b cnt=%0d",
                 i, got.rdy, got.cd, got.ce, got.ph, got.ll, got.cnt,
                 e.rdy, e.cd, e.ce, e.ph, e.ll, e.cnt);
      end
    end
    pll_lock = 1'b1; div_load = 1'b0; lock_lost_clr = 1'b0;

    // Asynchronous reset in RUN at phase 3 after switching to N=6
    div_load = 1'b1; div_sel = 4'd6;
    @(posedge clk); #1;
    div_load = 1'b0;
    begin
      int n = 0;
      while (!(phase == 4'd3 && ready) && n < 30) begin
        @(posedge clk); #1;
        n++;
      end
      check1("reach_phase3", int'(phase == 4'd3), 1);
    end
    #2 rst = 1'b1;
    #1 check1("async_reset_outputs",
              int'({ready, clk_div, clk_en, phase, lock_lost, lock_lost_count}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      check1($sformatf("post_reset_ready_e%0d", k), int'(ready), int'(k == 6));
    end
    check1("post_reset_start", int'({clk_en, clk_div, phase}), 6'b110000);
    begin
      int per = 0;
      int hi = 1;
      do begin
        @(posedge clk); #1;
        per++;
        if (!clk_en) hi += int'(clk_div);
      end while (!clk_en && per < 20);
      check1("default_period", per, 5);
      check1("default_high", hi, 2);
    end

    // Saturation of a 2-bit loss counter (LOCK_HOLD=1: ready on the 4th edge)
    pll_lock2 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check1($sformatf("hold1_ready_e%0d", k), int'(ready2), int'(k == 3));
    end
    for (int i = 1; i <= 5; i++) begin
      pll_lock2 = 1'b0;
      wait_ready2(1'b0, $sformatf("drop%0d", i));
      check1($sformatf("sat_cnt%0d", i), int'(lost_cnt2), (i < 3) ? i : 3);
      pll_lock2 = 1'b1;
      wait_ready2(1'b1, $sformatf("relock%0d", i));
    end
    check1("sat_final_cnt", int'(lost_cnt2), 3);
    check1("sat_lock_lost", int'(lock_lost2), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_div_sequencer.md
Name: clock_div_sequencer

Overview:
- Parametrised, vendor-neutral successor to the fixed ÷5 HDMI pixel-clock divider.
- Runs on the fast serial clock from the PLL and produces:
  - a divided clock with a runtime-programmable ratio;
  - a one-cycle clock-enable strobe;
  - a phase index.
- Gates all outputs until PLL lock has been stable for a programmable settle time, and tracks loss-of-lock events.
- Sits between the PLL wrapper and the TMDS serialiser/pixel pipeline.

Parameters:
- DIV_WIDTH, 4: width of divisor and phase.
- DIV_DEFAULT, 5: divisor after reset. Must be ≥2.
- LOCK_HOLD, 255: cycles of continuous synchronised lock required before RUN. Must be ≥1.
- CNT_WIDTH, 8: width of the settle counter and of lock_lost_count.

Ports:
- clk  in  1: fast clock (PLL output).
- rst  in  1: asynchronous, active-high reset.
- pll_lock  in  1: raw PLL lock, asynchronous to clk.
- div_sel  in  DIV_WIDTH: requested divisor.
- div_load  in  1: one-cycle strobe; capture div_sel.
- lock_lost_clr  in  1: clears the lock_lost flag.
- clk_div  out  1: divided clock.
- clk_en  out  1: high for one clk cycle at the start of each divided period.
- phase  out  DIV_WIDTH: position within the current period, 0..div_cur-1.
- ready  out  1: high while in RUN.
- lock_lost  out  1: sticky; set when lock drops in SETTLE or RUN.
- lock_lost_count  out  CNT_WIDTH: saturating count of lock-loss events.

Behaviour:
- Reset values:
  - state=WAIT_LOCK; sync flops=0.
  - clk_div=0, clk_en=0, phase=0, ready=0.
  - lock_lost=0, lock_lost_count=0.
  - div_cur=DIV_DEFAULT; pend=0.
- Lock synchroniser: pll_lock passes through a 2-flop synchroniser to give slock. Two cycles of latency.
- State WAIT_LOCK:
  - All divider outputs are held at 0.
  - slock=1 → SETTLE, with settle counter=0.
- State SETTLE:
  - Counter increments each cycle while slock=1.
  - slock=0 → WAIT_LOCK; lock_lost set; count incremented.
  - Counter reaching LOCK_HOLD-1 with slock=1 → RUN on the next edge.
- Entry timing: ready rises on the (LOCK_HOLD+3)th rising edge, counting the first edge at which pll_lock is sampled high. On that same edge phase=0, clk_en=1, clk_div=1.
- State RUN:
  - phase counts 0..div_cur-1, then wraps to 0.
  - clk_en=1 exactly when phase==0.
  - clk_div=1 when phase < div_cur>>1 (floor), otherwise 0. Example: N=5 gives 2 cycles high, 3 low; N=4 gives 2/2.
  - All three outputs are registered and mutually aligned.
  - slock=0 → next edge WAIT_LOCK:
    - ready, clk_div, clk_en and phase → 0;
    - lock_lost=1;
    - lock_lost_count increments, saturating at all-ones.
- Divisor load:
  - div_load captures div_sel into div_pend and sets pend.
  - A value <2 is clamped to 2.
  - Several loads before application: the last one wins.
  - If not in RUN, the pending value is applied on the next edge.
  - In RUN, it is applied at the wrap (the cycle with phase==div_cur-1); the following phase 0 uses the new div_cur. No truncated or runt period is ever produced.
  - A load in the wrap cycle itself takes effect at that wrap.
- lock_lost clear: lock_lost_clr clears lock_lost; a simultaneous set wins. lock_lost_count is cleared only by rst.
- Reset mid-operation: all state returns to reset values asynchronously. Deassertion restarts from WAIT_LOCK, and the full settle sequence must complete again.
- pll_lock glitches shorter than one clk cycle may or may not be seen. If seen, they are treated as a genuine loss.

Test Plan:
- Defaults with LOCK_HOLD=4; raise pll_lock at edge 0 → ready rises at edge 6 (the 7th). Then clk_en every 5 cycles, clk_div pattern 1,1,0,0,0, phase sequence 0,1,2,3,4,0.
- In RUN with N=5, pulse div_load with div_sel=8 at phase 1 → current period finishes at 5 cycles. The next period is 8 cycles, clk_div 4 high / 4 low, with no runt period.
- div_sel=0 then div_sel=1 loaded → both clamp to 2; clk_div toggles every cycle; clk_en every 2nd cycle.
- Drop pll_lock in RUN → 3 edges later ready=0, clk_div=0, lock_lost=1, lock_lost_count=1. Restoring lock → full settle again. lock_lost_clr together with a new loss leaves lock_lost=1.
- Drop pll_lock mid-SETTLE, after 2 of 4 settle cycles → return to WAIT_LOCK and lock_lost_count increments. Re-lock → ready comes LOCK_HOLD+3 edges after the re-lock.
- Assert rst in RUN at phase 3 → outputs 0 immediately (asynchronously), div_cur=5. With CNT_WIDTH=2, force 5 losses → lock_lost_count saturates at 3.
